// File: rtl/noc_axis_egress_unpacker.sv
// Ejection-side NoC network interface.
// Accepts 64-bit flits from the local router port and rebuilds the AXI-Stream
// packet on a 32-bit master port, restoring TID, TDEST and TLAST.
//
// Handshake rule, for both the flit port and the AXIS port: a transfer happens
// on a rising clk_i edge where valid and ready are both 1. A source keeps valid
// and its payload stable until that edge. The AXIS side follows this rule.
// flit_ready_o depends combinationally on m_axis_tready.
module noc_axis_egress_unpacker #(
    parameter int FLIT_WIDTH      = 64,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int TDATA_WIDTH     = 32,
    parameter int TID_WIDTH       = 5,
    parameter int TDEST_WIDTH     = 11,
    parameter int LEN_WIDTH       = 8,
    parameter int PKT_CNT_WIDTH   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [FLIT_WIDTH-1:0]      flit_i,
    input  logic [FLIT_TYPE_WIDTH-1:0] flit_type_i,
    input  logic                       flit_valid_i,
    output logic                       flit_ready_o,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [TID_WIDTH-1:0]       m_axis_tid,
    output logic [TDEST_WIDTH-1:0]     m_axis_tdest,
    output logic                       m_axis_tlast,
    output logic                       err_o,
    output logic [PKT_CNT_WIDTH-1:0]   pkt_count_o
);

    // Header field positions: switch id occupies [10:0] and is ignored here.
    localparam int TDEST_LSB = 11;
    localparam int TID_LSB   = TDEST_LSB + TDEST_WIDTH;
    localparam int LEN_LSB   = TID_LSB + TID_WIDTH;

    // Remaining-word counter must hold len+1, i.e. up to 2^LEN_WIDTH.
    localparam int REM_WIDTH = LEN_WIDTH + 1;
    localparam logic [REM_WIDTH-1:0] REM_ONE = REM_WIDTH'(1);
    localparam logic [REM_WIDTH-1:0] REM_TWO = REM_WIDTH'(2);

    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_HEADER      = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_TAIL        = FLIT_TYPE_WIDTH'(2);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_HEADER_TAIL = FLIT_TYPE_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [FLIT_WIDTH-1:0]    buf_q, buf_d;
    logic                     buf_valid_q, buf_valid_d;
    logic                     half_q, half_d;        // 0: low word, 1: high word
    logic                     buf_tail_q, buf_tail_d; // buffered flit ends the packet
    logic [TID_WIDTH-1:0]     tid_q, tid_d;
    logic [TDEST_WIDTH-1:0]   tdest_q, tdest_d;
    logic [REM_WIDTH-1:0]     rem_q, rem_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                     err_q, err_d;

    logic ready_c;
    logic tvalid_c;
    logic flit_acc;
    logic beat_hs;
    logic in_is_tail;
    logic in_is_hdr;
    logic cur_last_word;
    logic cur_tlast;

    // Flit port and AXIS beat decode shared by the FSM and the outputs.
    always_comb begin
        flit_acc      = flit_valid_i && flit_ready_o;
        beat_hs       = tvalid_c && m_axis_tready;
        in_is_tail    = (flit_type_i == FT_TAIL) || (flit_type_i == FT_HEADER_TAIL);
        in_is_hdr     = (flit_type_i == FT_HEADER) || (flit_type_i == FT_HEADER_TAIL);
        // A buffered flit runs out after its high word, or after its low word
        // when that word closes the packet (odd count drops the high half).
        cur_last_word = half_q || (rem_q == REM_ONE);
        cur_tlast     = (rem_q == REM_ONE) || (buf_tail_q && half_q);
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        half_d      = half_q;
        buf_tail_d  = buf_tail_q;
        tid_d       = tid_q;
        tdest_d     = tdest_q;
        rem_d       = rem_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_d       = 1'b0;
        ready_c     = 1'b0;
        tvalid_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (flit_acc) begin
                    if (flit_type_i == FT_HEADER) begin
                        tdest_d     = flit_i[TDEST_LSB +: TDEST_WIDTH];
                        tid_d       = flit_i[TID_LSB +: TID_WIDTH];
                        rem_d       = {1'b0, flit_i[LEN_LSB +: LEN_WIDTH]} + REM_ONE;
                        buf_valid_d = 1'b0;
                        half_d      = 1'b0;
                        state_d     = ST_DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                tvalid_c = buf_valid_q;
                // Refill in the same cycle the last usable word leaves, so
                // consecutive flits stream at one word per cycle. The beat that
                // closes the packet does not refill: the next flit belongs to
                // IDLE or DISCARD, not to this packet.
                ready_c  = !buf_valid_q || (beat_hs && cur_last_word && !cur_tlast);

                if (beat_hs) begin
                    rem_d = rem_q - REM_ONE;
                    if (cur_tlast) begin
                        pkt_cnt_d   = pkt_cnt_q + PKT_CNT_WIDTH'(1);
                        buf_valid_d = 1'b0;
                        half_d      = 1'b0;
                        if (buf_tail_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            // Word count ran out inside a body flit: the tail
                            // is still in flight and must be swallowed.
                            err_d   = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end else if (cur_last_word) begin
                        buf_valid_d = 1'b0;
                        half_d      = 1'b0;
                    end else begin
                        half_d = 1'b1;
                    end
                end

                if (flit_acc) begin
                    buf_d       = flit_i;
                    buf_valid_d = 1'b1;
                    half_d      = 1'b0;
                    buf_tail_d  = in_is_tail;
                    // Header types inside a packet are carried as data.
                    if (in_is_hdr) begin
                        err_d = 1'b1;
                    end
                    // Tail arriving while more than two words are still owed.
                    if (in_is_tail && (rem_d > REM_TWO)) begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_DISCARD: begin
                ready_c = 1'b1;
                if (flit_acc && in_is_tail) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flit buffer, packet context and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            half_q      <= 1'b0;
            buf_tail_q  <= 1'b0;
            tid_q       <= '0;
            tdest_q     <= '0;
            rem_q       <= '0;
            pkt_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            half_q      <= half_d;
            buf_tail_q  <= buf_tail_d;
            tid_q       <= tid_d;
            tdest_q     <= tdest_d;
            rem_q       <= rem_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_q       <= err_d;
        end
    end

    // Output drive; ready is held low while reset is asserted.
    always_comb begin
        flit_ready_o  = rst_ni && ready_c;
        m_axis_tvalid = tvalid_c;
        m_axis_tdata  = half_q ? buf_q[FLIT_WIDTH-1 -: TDATA_WIDTH] : buf_q[TDATA_WIDTH-1:0];
        m_axis_tid    = tid_q;
        m_axis_tdest  = tdest_q;
        m_axis_tlast  = tvalid_c && cur_tlast;
        err_o         = err_q;
        pkt_count_o   = pkt_cnt_q;
    end

endmodule

// File: tb/tb_noc_axis_egress_unpacker.sv
// Directed bench for noc_axis_egress_unpacker.
module tb_noc_axis_egress_unpacker;

  localparam logic [1:0] T_HDR  = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] flit = '0;
  logic [1:0]  flit_type = '0;
  logic        flit_valid = 1'b0;
  logic        flit_ready;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic [4:0]  tid;
  logic [10:0] tdest;
  logic        tlast;
  logic        err;
  logic [15:0] pkt_count;

  noc_axis_egress_unpacker dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flit_i        (flit),
    .flit_type_i   (flit_type),
    .flit_valid_i  (flit_valid),
    .flit_ready_o  (flit_ready),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tid    (tid),
    .m_axis_tdest  (tdest),
    .m_axis_tlast  (tlast),
    .err_o         (err),
    .pkt_count_o   (pkt_count)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic [31:0] got_data[$];
  logic        got_last[$];
  logic [4:0]  got_tid[$];
  logic [10:0] got_tdest[$];
  int          err_cnt  = 0;
  int          stab_err = 0;
  int          ovf_err  = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  // tready pattern: 0 -> always 1, 1 -> toggle, 2 -> held 0, 3 -> manual
  int tready_mode = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: tready = 1'b1;
        1: tready = ~tready;
        2: tready = 1'b0;
        default: ;
      endcase
    end
  end

  // Observe the AXIS port half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (tvalid && tready) begin
        got_data.push_back(tdata);
        got_last.push_back(tlast);
        got_tid.push_back(tid);
        got_tdest.push_back(tdest);
      end
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stab_err++;
      if (flit_valid && flit_ready && tvalid && !tready) ovf_err++;
      if (err) err_cnt++;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] mk_hdr(input logic [10:0] dest, input logic [4:0] id,
                                         input logic [7:0] len);
    logic [63:0] h;
    h = '0;
    h[10:0]  = 11'h5A5;
    h[21:11] = dest;
    h[26:22] = id;
    h[34:27] = len;
    h[63:40] = 24'hFFFFFF;
    return h;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_flit(input logic [63:0] d, input logic [1:0] t);
    bit done;
    done = 0;
    flit = d;
    flit_type = t;
    flit_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (flit_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    flit_valid = 1'b0;
    if (!done) begin
      total_cnt++;
      $display("FAIL send_flit_timeout type=%0d data=%h", t, d);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    exp_last_q.delete();
    got_data.delete();
    got_last.delete();
    got_tid.delete();
    got_tdest.delete();
    err_cnt  = 0;
    stab_err = 0;
    ovf_err  = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tready_mode = 0;
    #23;
    total_cnt++;
    if (flit_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", flit_ready);
    else pass_cnt++;
    total_cnt++;
    if ({tvalid, tlast, err, tdata} !== 35'd0)
      $display("FAIL reset_axis got v=%b l=%b e=%b d=%h exp=0", tvalid, tlast, err, tdata);
    else pass_cnt++;
    total_cnt++;
    if (pkt_count !== 16'd0) $display("FAIL reset_pkt got=%0d exp=0", pkt_count);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (flit_ready !== 1'b1) $display("FAIL idle_ready got=%b exp=1", flit_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    clear_sb();
    tready_mode = 0;
    exp_q = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    send_flit(mk_hdr(11'h123, 5'd5, 8'd3), T_HDR);
    send_flit(64'hBBBB0002_AAAA0001, T_BODY);
    send_flit(64'hDDDD0004_CCCC0003, T_TAIL);
    wait_cycles(8);
    total_cnt++;
    if (got_data.size() !== 4) $display("FAIL basic_count got=%0d exp=4", got_data.size());
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i] ||
          got_tid[i] !== 5'd5 || got_tdest[i] !== 11'h123)
        $display("FAIL basic_beat%0d got=%h exp=%h last_exp=%b", i,
                 (i < got_data.size()) ? got_data[i] : 32'hx, exp_q[i], exp_last_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (pkt_count !== 16'd1) $display("FAIL basic_pkt got=%0d exp=1", pkt_count);
    else pass_cnt++;
    total_cnt++;
    if (err_cnt !== 0) $display("FAIL basic_err got=%0d exp=0", err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_len0();
    clear_sb();
    send_flit(mk_hdr(11'h001, 5'd1, 8'd0), T_HDR);
    send_flit(64'h22222222_11111111, T_TAIL);
    wait_cycles(5);
    total_cnt++;
    if (got_data.size() !== 1 || got_data[0] !== 32'h11111111 || got_last[0] !== 1'b1)
      $display("FAIL len0_beat got_n=%0d got=%h exp=11111111 tlast=1", got_data.size(),
               (got_data.size() > 0) ? got_data[0] : 32'hx);
    else pass_cnt++;
    total_cnt++;
    if (flit_ready !== 1'b1 || err_cnt !== 0)
      $display("FAIL len0_idle got ready=%b err=%0d exp ready=1 err=0", flit_ready, err_cnt);
    else pass_cnt++;
    total_cnt++;
    if (pkt_count !== 16'd2) $display("FAIL len0_pkt got=%0d exp=2", pkt_count);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    clear_sb();
    tready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h1000_0001 + i);
      exp_last_q.push_back(i == 7);
    end
    send_flit(mk_hdr(11'h3FF, 5'd31, 8'd7), T_HDR);
    for (int k = 0; k < 4; k++)
      send_flit({32'h1000_0002 + 2 * k, 32'h1000_0001 + 2 * k}, (k == 3) ? T_TAIL : T_BODY);
    wait_cycles(10);
    tready_mode = 0;
    total_cnt++;
    if (got_data.size() !== 8) $display("FAIL bp_count got=%0d exp=8", got_data.size());
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i] ||
          got_tid[i] !== 5'd31 || got_tdest[i] !== 11'h3FF)
        $display("FAIL bp_beat%0d got=%h exp=%h last_exp=%b", i,
                 (i < got_data.size()) ? got_data[i] : 32'hx, exp_q[i], exp_last_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stab_err !== 0 || ovf_err !== 0)
      $display("FAIL bp_stall got stab=%0d ovf=%0d exp=0/0", stab_err, ovf_err);
    else pass_cnt++;
    total_cnt++;
    if (pkt_count !== 16'd3 || err_cnt !== 0)
      $display("FAIL bp_pkt got pkt=%0d err=%0d exp pkt=3 err=0", pkt_count, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_idle_err();
    clear_sb();
    send_flit(64'h12345678_9ABCDEF0, T_BODY);
    wait_cycles(4);
    total_cnt++;
    if (err_cnt !== 1) $display("FAIL idle_err_pulse got=%0d cycles exp=1", err_cnt);
    else pass_cnt++;
    total_cnt++;
    if (got_data.size() !== 0 || pkt_count !== 16'd3)
      $display("FAIL idle_err_drop got beats=%0d pkt=%0d exp 0/3", got_data.size(), pkt_count);
    else pass_cnt++;
  endtask

  // Word count ends inside the third body flit; the tail must be swallowed.
  task automatic test_late_tail();
    clear_sb();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'h5000_0001 + i);
      exp_last_q.push_back(i == 5);
    end
    exp_q.push_back(32'h6000_0001);
    exp_last_q.push_back(1'b0);
    exp_q.push_back(32'h6000_0002);
    exp_last_q.push_back(1'b1);
    send_flit(mk_hdr(11'h042, 5'd2, 8'd5), T_HDR);
    for (int k = 0; k < 3; k++)
      send_flit({32'h5000_0002 + 2 * k, 32'h5000_0001 + 2 * k}, T_BODY);
    send_flit(64'hEEEEEEEE_EEEEEEEE, T_TAIL);
    wait_cycles(3);
    total_cnt++;
    if (err_cnt !== 1 || pkt_count !== 16'd4)
      $display("FAIL late_tail_err got err=%0d pkt=%0d exp 1/4", err_cnt, pkt_count);
    else pass_cnt++;
    send_flit(mk_hdr(11'h043, 5'd3, 8'd1), T_HDR);
    send_flit(64'h60000002_60000001, T_TAIL);
    wait_cycles(5);
    total_cnt++;
    if (got_data.size() !== 8) $display("FAIL late_tail_count got=%0d exp=8", got_data.size());
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i])
        $display("FAIL late_tail_beat%0d got=%h exp=%h last_exp=%b", i,
                 (i < got_data.size()) ? got_data[i] : 32'hx, exp_q[i], exp_last_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (pkt_count !== 16'd5 || err_cnt !== 1)
      $display("FAIL late_tail_after got pkt=%0d err=%0d exp 5/1", pkt_count, err_cnt);
    else pass_cnt++;
  endtask

  // Tail arrives after only two of eight words: both tail words go out, last one flagged.
  task automatic test_early_tail();
    clear_sb();
    exp_q = '{32'h7000_0001, 32'h7000_0002, 32'h7000_0003, 32'h7000_0004};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    send_flit(mk_hdr(11'h077, 5'd7, 8'd7), T_HDR);
    send_flit(64'h70000002_70000001, T_BODY);
    send_flit(64'h70000004_70000003, T_TAIL);
    wait_cycles(6);
    total_cnt++;
    if (got_data.size() !== 4) $display("FAIL early_count got=%0d exp=4", got_data.size());
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_last[i] !== exp_last_q[i])
        $display("FAIL early_beat%0d got=%h exp=%h last_exp=%b", i,
                 (i < got_data.size()) ? got_data[i] : 32'hx, exp_q[i], exp_last_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (err_cnt !== 1 || pkt_count !== 16'd6 || flit_ready !== 1'b1)
      $display("FAIL early_end got err=%0d pkt=%0d rdy=%b exp 1/6/1", err_cnt, pkt_count, flit_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_sb();
    tready_mode = 2;
    wait_cycles(1);
    send_flit(mk_hdr(11'h200, 5'd9, 8'd3), T_HDR);
    send_flit(64'hBBBB0002_AAAA0001, T_BODY);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tvalid) seen = 1;
    end
    tready_mode = 3;
    #1 tready = 1'b1;
    @(posedge clk);
    #1 tready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (tvalid !== 1'b1 || tdata !== 32'hBBBB0002)
      $display("FAIL mid_pending got v=%b d=%h exp v=1 d=BBBB0002", tvalid, tdata);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (tvalid !== 1'b0 || flit_ready !== 1'b0)
      $display("FAIL mid_async got v=%b rdy=%b exp 0/0", tvalid, flit_ready);
    else pass_cnt++;
    wait_cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    tready_mode = 0;
    wait_cycles(1);
    clear_sb();
    total_cnt++;
    if (pkt_count !== 16'd0 || tvalid !== 1'b0)
      $display("FAIL mid_after_rst got pkt=%0d v=%b exp 0/0", pkt_count, tvalid);
    else pass_cnt++;
    send_flit(mk_hdr(11'h201, 5'd10, 8'd1), T_HDR);
    send_flit(64'h0000BEEF_0000CAFE, T_TAIL);
    wait_cycles(5);
    total_cnt++;
    if (got_data.size() !== 2 || got_data[0] !== 32'h0000CAFE || got_data[1] !== 32'h0000BEEF ||
        got_last[0] !== 1'b0 || got_last[1] !== 1'b1 || got_tid[0] !== 5'd10)
      $display("FAIL mid_new_pkt got_n=%0d first=%h exp n=2 first=0000CAFE", got_data.size(),
               (got_data.size() > 0) ? got_data[0] : 32'hx);
    else pass_cnt++;
    total_cnt++;
    if (pkt_count !== 16'd1) $display("FAIL mid_pkt got=%0d exp=1", pkt_count);
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_backpressure();
    test_idle_err();
    test_late_tail();
    test_early_tail();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
